// File: rtl/mem_req_issue_pkg.sv
// Shared encodings for the EX->MEM memory request issue stage.
// The exception bit order matches the MMU address convertor's vector.
package mem_req_issue_pkg;

   // Issue-stage FSM states
   typedef enum logic [2:0] {
      MRI_IDLE      = 3'd0,
      MRI_ADDR      = 3'd1,
      MRI_ADDR_KILL = 3'd2,
      MRI_DATA      = 3'd3,
      MRI_RESP      = 3'd4
   } mri_state_t;

   // Access size encodings carried on in_size / bus_size
   localparam logic [1:0] MRI_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MRI_SIZE_HALF = 2'd1;
   localparam logic [1:0] MRI_SIZE_WORD = 2'd2;

   // One-hot operation type bit positions: {Fetch, Load, Store}
   localparam int unsigned MRI_OPE_STORE = 0;
   localparam int unsigned MRI_OPE_LOAD  = 1;
   localparam int unsigned MRI_OPE_FETCH = 2;

   // Exception vector bit positions: {PIL, PIS, PIF, PME, PPI, TLBR}
   localparam int unsigned MRI_EXC_TLBR = 0;
   localparam int unsigned MRI_EXC_PPI  = 1;
   localparam int unsigned MRI_EXC_PME  = 2;
   localparam int unsigned MRI_EXC_PIF  = 3;
   localparam int unsigned MRI_EXC_PIS  = 4;
   localparam int unsigned MRI_EXC_PIL  = 5;

endpackage

// File: rtl/mem_req_issue.sv
// Memory request issue stage: takes one translated operation at a time,
// drives it onto the SRAM-like bus, collects the in-order response and
// hands the result on. Translation exceptions bypass the bus entirely.
// Responses that belong to flushed operations are counted and swallowed.
module mem_req_issue
   import mem_req_issue_pkg::*;
#(
   parameter int unsigned CNT_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_ope_type,
   input  logic [1:0]  in_size,
   input  logic [3:0]  in_wstrb,
   input  logic [31:0] in_wdata,
   input  logic [31:0] tr_pa,
   input  logic [1:0]  tr_mat,
   input  logic        tr_has_except,
   input  logic [5:0]  tr_except,
   input  logic        flush,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   output logic [1:0]  bus_mat,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic        out_has_except,
   output logic [5:0]  out_except
);

   mri_state_t       state_r;
   mri_state_t       state_nxt_s;
   logic [CNT_W-1:0] discard_cnt_r;
   logic             cnt_full_s;
   logic             cnt_zero_s;
   logic             cnt_inc_s;
   logic             cnt_dec_s;
   logic             accept_s;
   logic             own_resp_s;
   logic             unused_ope_s;

   // Fetch and load both read; only the store bit decides the direction.
   assign unused_ope_s = ^in_ope_type[MRI_OPE_FETCH:MRI_OPE_LOAD];

   assign cnt_full_s = &discard_cnt_r;
   assign cnt_zero_s = (discard_cnt_r == {CNT_W{1'b0}});
   assign in_ready   = (state_r == MRI_IDLE) & ~flush & ~cnt_full_s;
   assign accept_s   = in_valid & in_ready;

   // Bus request and result valid depend on the state register only.
   assign bus_req   = (state_r == MRI_ADDR) | (state_r == MRI_ADDR_KILL);
   assign out_valid = (state_r == MRI_RESP);

   // Orphan responses always come back first, so any data_ok seen while the
   // counter is non-zero belongs to a killed operation.
   assign cnt_dec_s  = bus_data_ok & ~cnt_zero_s;
   assign own_resp_s = (state_r == MRI_DATA) & bus_data_ok & cnt_zero_s;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= MRI_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and detection of operations killed after issue
   always_comb begin
      state_nxt_s = state_r;
      cnt_inc_s   = 1'b0;
      case (state_r)
         MRI_IDLE: begin
            if (accept_s) begin
               state_nxt_s = tr_has_except ? MRI_RESP : MRI_ADDR;
            end else begin
               state_nxt_s = MRI_IDLE;
            end
         end
         MRI_ADDR: begin
            if (flush) begin
               if (bus_addr_ok) begin
                  state_nxt_s = MRI_IDLE;
                  cnt_inc_s   = 1'b1;
               end else begin
                  state_nxt_s = MRI_ADDR_KILL;
               end
            end else if (bus_addr_ok) begin
               state_nxt_s = MRI_DATA;
            end else begin
               state_nxt_s = MRI_ADDR;
            end
         end
         MRI_ADDR_KILL: begin
            // A posted request cannot be withdrawn; wait for its acceptance.
            if (bus_addr_ok) begin
               state_nxt_s = MRI_IDLE;
               cnt_inc_s   = 1'b1;
            end else begin
               state_nxt_s = MRI_ADDR_KILL;
            end
         end
         MRI_DATA: begin
            if (flush) begin
               // Own response arriving with the flush is simply dropped.
               state_nxt_s = MRI_IDLE;
               cnt_inc_s   = ~own_resp_s;
            end else if (own_resp_s) begin
               state_nxt_s = MRI_RESP;
            end else begin
               state_nxt_s = MRI_DATA;
            end
         end
         MRI_RESP: begin
            if (flush | out_ready) begin
               state_nxt_s = MRI_IDLE;
            end else begin
               state_nxt_s = MRI_RESP;
            end
         end
         default: begin
            state_nxt_s = MRI_IDLE;
         end
      endcase
   end

   // Outstanding-orphan counter; simultaneous kill and orphan cancel out
   always_ff @(posedge clk) begin
      if (reset) begin
         discard_cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_inc_s & ~cnt_dec_s & ~cnt_full_s) begin
         discard_cnt_r <= discard_cnt_r + CNT_W'(1);
      end else if (cnt_dec_s & ~cnt_inc_s) begin
         discard_cnt_r <= discard_cnt_r - CNT_W'(1);
      end else begin
         discard_cnt_r <= discard_cnt_r;
      end
   end

   // Bus request fields, captured once at acceptance and held while issued
   always_ff @(posedge clk) begin
      if (reset) begin
         bus_wr    <= 1'b0;
         bus_size  <= 2'd0;
         bus_addr  <= 32'd0;
         bus_wstrb <= 4'd0;
         bus_wdata <= 32'd0;
         bus_mat   <= 2'd0;
      end else if (accept_s & ~tr_has_except) begin
         bus_wr    <= in_ope_type[MRI_OPE_STORE];
         bus_size  <= in_size;
         bus_addr  <= tr_pa;
         bus_wstrb <= in_wstrb;
         bus_wdata <= in_wdata;
         bus_mat   <= tr_mat;
      end else begin
         bus_wr    <= bus_wr;
         bus_size  <= bus_size;
         bus_addr  <= bus_addr;
         bus_wstrb <= bus_wstrb;
         bus_wdata <= bus_wdata;
         bus_mat   <= bus_mat;
      end
   end

   // Result payload: exception latched at accept, read data on own response
   always_ff @(posedge clk) begin
      if (reset) begin
         out_rdata      <= 32'd0;
         out_has_except <= 1'b0;
         out_except     <= 6'd0;
      end else if (accept_s) begin
         out_rdata      <= 32'd0;
         out_has_except <= tr_has_except;
         out_except     <= tr_has_except ? tr_except : 6'd0;
      end else if (own_resp_s & ~flush) begin
         out_rdata      <= bus_wr ? 32'd0 : bus_rdata;
         out_has_except <= out_has_except;
         out_except     <= out_except;
      end else begin
         out_rdata      <= out_rdata;
         out_has_except <= out_has_except;
         out_except     <= out_except;
      end
   end

endmodule

// File: doc/mem_req_issue.md
Name: mem_req_issue

Overview:
- Sits directly downstream of the MMU address convertor, in the EX→MEM boundary of the LoongArch pipeline.
- Takes one memory operation per handshake, together with the convertor's physical address, MAT and exception vector, in the same cycle.
- Issues the access on the SRAM-like bus toward the AXI bridge and collects the response, or short-circuits translation exceptions without touching the bus.
- Hands the result to the next stage and discards responses belonging to flushed operations.

Parameters:
- CNT_W, 2, width of the discard counter; at most 2^CNT_W-1 orphaned responses are tracked.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation valid from the pipeline
- in_ready  out  1  block can accept an operation
- in_ope_type  in  3  {Fetch, Load, Store}, one-hot
- in_size  in  2  0=byte, 1=half, 2=word
- in_wstrb  in  4  byte strobes, stores only
- in_wdata  in  32  store data
- tr_pa  in  32  physical address from the convertor
- tr_mat  in  2  memory access type from the convertor
- tr_has_except  in  1  translation exception present
- tr_except  in  6  {PIL, PIS, PIF, PME, PPI, TLBR}
- flush  in  1  pipeline flush (exception or ertn), kills the in-flight operation
- bus_req  out  1  request
- bus_wr  out  1  1 = write
- bus_size  out  2  access size
- bus_addr  out  32  physical address
- bus_wstrb  out  4  write strobes
- bus_wdata  out  32  write data
- bus_mat  out  2  MAT; 0 = strongly-ordered uncached
- bus_addr_ok  in  1  address accepted
- bus_data_ok  in  1  response returned, in order
- bus_rdata  in  32  read data
- out_valid  out  1  result valid
- out_ready  in  1  next stage accepts the result
- out_rdata  out  32  load/fetch data; 0 for stores and exceptions
- out_has_except  out  1  exception accompanies the result
- out_except  out  6  latched exception vector

Behaviour:
- Reset values: state IDLE, discard_cnt 0, every bus_* and out_* output 0.
- Handshake: an operation is accepted on in_valid & in_ready. in_ready = (state==IDLE) & ~flush & (discard_cnt != all-ones).
- tr_* is sampled in the acceptance cycle only.
- States:
  - IDLE:
    - accept with tr_has_except=1 → RESP. Latch the exception and issue no bus request.
    - accept without an exception → ADDR. Latch pa, mat, size, wstrb, wdata, and wr = ope_type[0].
  - ADDR:
    - bus_req=1 with stable fields.
    - addr_ok → DATA.
    - flush & ~addr_ok → ADDR_KILL.
    - flush & addr_ok → IDLE and discard_cnt+1.
  - ADDR_KILL:
    - bus_req stays 1 because a request cannot be withdrawn.
    - addr_ok → IDLE and discard_cnt+1.
    - flush has no further effect in this state.
  - DATA:
    - data_ok with discard_cnt==0 → latch rdata (stores latch 0) and go to RESP.
    - flush → IDLE and discard_cnt+1. If data_ok arrives in the same cycle, the response is the operation's own: drop it and leave discard_cnt unchanged.
  - RESP:
    - out_valid=1.
    - out_ready → IDLE.
    - flush → IDLE, out_valid drops the next cycle.
- Discard rule:
  - data_ok while discard_cnt>0: the response belongs to a killed operation. Decrement the counter and never forward it.
  - Priority: orphan responses are consumed before the current operation's response.
  - Increment and decrement in the same cycle leave discard_cnt unchanged.
- Latency: a non-excepting load takes at least 3 cycles from accept to out_valid (accept → ADDR → DATA → RESP). An excepting operation reaches out_valid 1 cycle after accept.
- bus_req is combinational from state only, never from in_*.
- No new request is accepted while in ADDR_KILL.

Decomposition:
- Shared macro header:
  - state encodings MRI_IDLE, MRI_ADDR, MRI_ADDR_KILL, MRI_DATA, MRI_RESP
  - size encodings
  - exception bit positions, shared with the convertor's vector order
- No sub-module. The discard counter is small enough to stay inline; a generic saturating up/down counter (sat_updown_cnt) is an acceptable optional split.

Test Plan:
- Load, tr_pa=0x1C000100, addr_ok after 2 cycles, data_ok with rdata=0xDEADBEEF after 3 more → one out_valid carrying rdata 0xDEADBEEF, out_has_except=0, bus_addr=0x1C000100, bus_wr=0.
- Store with tr_has_except=1, tr_except=6'b000100 (PME) → bus_req never asserts; out_valid the next cycle with out_except=000100 and out_rdata=0.
- Load accepted, flush in ADDR without addr_ok → bus_req held until addr_ok, discard_cnt=1. A new load is then accepted; the first data_ok (0x11111111) is dropped and the second (0x22222222) is delivered.
- Flush in DATA coinciding with data_ok → nothing forwarded, discard_cnt stays 0, in_ready=1 the following cycle.
- Three killed loads with CNT_W=2 → discard_cnt=3 and in_ready=0 until one orphan data_ok arrives.
- Reset asserted in DATA → all outputs 0 next cycle, discard_cnt=0, in_ready=1.
